// File: rtl/axi_lite_sram_if.sv
// AXI-lite bus bundle between the LSU (master) and the data SRAM (slave).
// Only the five handshaked channels live here; clock and reset stay plain ports.
interface axi_lite_sram_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi_lite_sram.sv
// AXI-lite data memory: independent read/write FSMs over a word array with byte strobes
// and programmable response latency on each channel.
module axi_lite_sram #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          READ_LAT    = 0,
    parameter int          WRITE_LAT   = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    axi_lite_sram_if.slave  bus
);
    localparam int          AW     = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN   = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  RLAT   = 4'(READ_LAT);
    localparam logic [3:0]  WLAT   = 4'(WRITE_LAT);
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rstate_e;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wstate_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wreq_t;

    // Returns {in_range, word_index}; subtraction wraps so addresses below BASE fail the range test.
    function automatic logic [AW:0] decode(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return {off < SPAN, off[AW+1:2]};
    endfunction

    logic [31:0] mem [DEPTH_WORDS];

    // ---------------- read channel ----------------
    rstate_e     rstate_q, rstate_d;
    logic [3:0]  rcnt_q, rcnt_d;
    logic [31:0] raddr_q, raddr_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [31:0] rd_addr;
    logic        r_load;
    logic [AW:0] rdec;

    always_comb begin
        rstate_d = rstate_q;
        rcnt_d   = rcnt_q;
        raddr_d  = raddr_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        rd_addr  = raddr_q;
        r_load   = 1'b0;
        case (rstate_q)
            R_IDLE: if (bus.arvalid) begin
                raddr_d = bus.araddr;
                rd_addr = bus.araddr;
                rcnt_d  = RLAT;
                if (READ_LAT == 0) begin
                    rstate_d = R_RESP;
                    r_load   = 1'b1;
                end else begin
                    rstate_d = R_WAIT;
                end
            end
            R_WAIT: begin
                rcnt_d = rcnt_q - 4'd1;
                if (rcnt_q == 4'd1) begin
                    rstate_d = R_RESP;
                    r_load   = 1'b1;
                end
            end
            R_RESP:  if (bus.rready) rstate_d = R_IDLE;
            default: rstate_d = R_IDLE;
        endcase
        rdec = decode(rd_addr);
        // Array read sees pre-edge contents, so a same-edge write commit is not visible here.
        if (r_load) begin
            if (rdec[AW]) begin
                rdata_d = mem[rdec[AW-1:0]];
                rresp_d = OKAY;
            end else begin
                rdata_d = '0;
                rresp_d = SLVERR;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rstate_q <= R_IDLE;
            rcnt_q   <= '0;
            raddr_q  <= '0;
            rdata_q  <= '0;
            rresp_q  <= OKAY;
        end else begin
            rstate_q <= rstate_d;
            rcnt_q   <= rcnt_d;
            raddr_q  <= raddr_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
        end
    end

    assign bus.arready = (rstate_q == R_IDLE);
    assign bus.rvalid  = (rstate_q == R_RESP);
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;

    // ---------------- write channel ----------------
    wstate_e     wstate_q, wstate_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic        aw_got_q, aw_got_d;
    logic        w_got_q, w_got_d;
    wreq_t       wreq_q, wreq_d, cmt;
    logic [1:0]  bresp_q, bresp_d;
    logic        w_cmt;
    logic        mem_we;
    logic [AW:0] wdec;

    always_comb begin
        wstate_d = wstate_q;
        wcnt_d   = wcnt_q;
        aw_got_d = aw_got_q;
        w_got_d  = w_got_q;
        wreq_d   = wreq_q;
        bresp_d  = bresp_q;
        cmt      = wreq_q;
        w_cmt    = 1'b0;
        mem_we   = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                if (bus.awvalid && !aw_got_q) begin
                    aw_got_d    = 1'b1;
                    wreq_d.addr = bus.awaddr;
                    cmt.addr    = bus.awaddr;
                end
                if (bus.wvalid && !w_got_q) begin
                    w_got_d     = 1'b1;
                    wreq_d.data = bus.wdata;
                    wreq_d.strb = bus.wstrb;
                    cmt.data    = bus.wdata;
                    cmt.strb    = bus.wstrb;
                end
                if (aw_got_d && w_got_d) begin
                    wcnt_d = WLAT;
                    if (WRITE_LAT == 0) begin
                        wstate_d = W_RESP;
                        w_cmt    = 1'b1;
                    end else begin
                        wstate_d = W_WAIT;
                    end
                end
            end
            W_WAIT: begin
                wcnt_d = wcnt_q - 4'd1;
                if (wcnt_q == 4'd1) begin
                    wstate_d = W_RESP;
                    w_cmt    = 1'b1;
                end
            end
            W_RESP: if (bus.bready) begin
                wstate_d = W_IDLE;
                aw_got_d = 1'b0;
                w_got_d  = 1'b0;
            end
            default: wstate_d = W_IDLE;
        endcase
        wdec = decode(cmt.addr);
        if (w_cmt) begin
            mem_we  = wdec[AW];
            bresp_d = wdec[AW] ? OKAY : SLVERR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wstate_q <= W_IDLE;
            wcnt_q   <= '0;
            aw_got_q <= 1'b0;
            w_got_q  <= 1'b0;
            wreq_q   <= '0;
            bresp_q  <= OKAY;
        end else begin
            wstate_q <= wstate_d;
            wcnt_q   <= wcnt_d;
            aw_got_q <= aw_got_d;
            w_got_q  <= w_got_d;
            wreq_q   <= wreq_d;
            bresp_q  <= bresp_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (cmt.strb[i]) mem[wdec[AW-1:0]][8*i +: 8] <= cmt.data[8*i +: 8];
            end
        end
    end

    assign bus.awready = (wstate_q == W_IDLE) && !aw_got_q;
    assign bus.wready  = (wstate_q == W_IDLE) && !w_got_q;
    assign bus.bvalid  = (wstate_q == W_RESP);
    assign bus.bresp   = bresp_q;
endmodule

// File: tb/tb_axi_lite_sram.sv
// Directed bench: a zero-latency instance driven from a vector table, and a
// READ_LAT=3 / WRITE_LAT=2 instance exercised by hand-written handshake sequences.
module tb_axi_lite_sram;
    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    axi_lite_sram_if bus0 ();
    axi_lite_sram_if bus1 ();

    axi_lite_sram #(.BASE_ADDR(32'h8000_0000), .DEPTH_WORDS(1024), .READ_LAT(0), .WRITE_LAT(0))
        u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    axi_lite_sram #(.BASE_ADDR(32'h8000_0000), .DEPTH_WORDS(1024), .READ_LAT(3), .WRITE_LAT(2))
        u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t tv [14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic wr(input bit sel, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [1:0] resp, output int lat);
        if (sel) begin
            bus1.awaddr = a; bus1.wdata = d; bus1.wstrb = s;
            bus1.awvalid = 1'b1; bus1.wvalid = 1'b1; bus1.bready = 1'b1;
        end else begin
            bus0.awaddr = a; bus0.wdata = d; bus0.wstrb = s;
            bus0.awvalid = 1'b1; bus0.wvalid = 1'b1; bus0.bready = 1'b1;
        end
        tick();
        bus0.awvalid = 1'b0; bus0.wvalid = 1'b0;
        bus1.awvalid = 1'b0; bus1.wvalid = 1'b0;
        lat = 1;
        while (!(sel ? bus1.bvalid : bus0.bvalid) && lat < 30) begin
            tick();
            lat++;
        end
        resp = sel ? bus1.bresp : bus0.bresp;
        tick();
    endtask

    task automatic rd(input bit sel, input logic [31:0] a,
                      output logic [31:0] data, output logic [1:0] resp, output int lat);
        if (sel) begin
            bus1.araddr = a; bus1.arvalid = 1'b1; bus1.rready = 1'b1;
        end else begin
            bus0.araddr = a; bus0.arvalid = 1'b1; bus0.rready = 1'b1;
        end
        tick();
        bus0.arvalid = 1'b0;
        bus1.arvalid = 1'b0;
        lat = 1;
        while (!(sel ? bus1.rvalid : bus0.rvalid) && lat < 30) begin
            tick();
            lat++;
        end
        data = sel ? bus1.rdata : bus0.rdata;
        resp = sel ? bus1.rresp : bus0.rresp;
        tick();
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;

        tv[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,          2'b00};
        tv[1]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF,  2'b00};
        tv[2]  = '{1'b1, 32'h8000_0000, 32'h1122_3344, 4'hF, 32'h0,          2'b00};
        tv[3]  = '{1'b1, 32'h8000_0000, 32'h0000_AA00, 4'h2, 32'h0,          2'b00};
        tv[4]  = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 32'h1122_AA44,  2'b00};
        tv[5]  = '{1'b1, 32'h8000_0FFF, 32'hA5A5_A5A5, 4'hF, 32'h0,          2'b00};
        tv[6]  = '{1'b1, 32'h8000_0004, 32'hCAFE_F00D, 4'hF, 32'h0,          2'b00};
        tv[7]  = '{1'b1, 32'h8000_0004, 32'h1234_5678, 4'h0, 32'h0,          2'b00};
        tv[8]  = '{1'b1, 32'h7FFF_FFFC, 32'h5555_5555, 4'hF, 32'h0,          2'b10};
        tv[9]  = '{1'b1, 32'h8000_1000, 32'h6666_6666, 4'hF, 32'h0,          2'b10};
        tv[10] = '{1'b0, 32'h7FFF_FFFC, 32'h0,         4'h0, 32'h0,          2'b10};
        tv[11] = '{1'b0, 32'h8000_0FFC, 32'h0,         4'h0, 32'hA5A5_A5A5,  2'b00};
        tv[12] = '{1'b0, 32'h8000_0004, 32'h0,         4'h0, 32'hCAFE_F00D,  2'b00};
        tv[13] = '{1'b0, 32'h8000_0002, 32'h0,         4'h0, 32'h1122_AA44,  2'b00};

        rst_n = 1'b1;
        {bus0.arvalid, bus0.rready, bus0.awvalid, bus0.wvalid, bus0.bready} = '0;
        {bus1.arvalid, bus1.rready, bus1.awvalid, bus1.wvalid, bus1.bready} = '0;
        bus0.araddr = '0; bus0.awaddr = '0; bus0.wdata = '0; bus0.wstrb = '0;
        bus1.araddr = '0; bus1.awaddr = '0; bus1.wdata = '0; bus1.wstrb = '0;
        #2 rst_n = 1'b0;
        tick(); tick();
        chk("reset0_ctl", 32'({bus0.rvalid, bus0.bvalid, bus0.rresp, bus0.bresp,
                               bus0.arready, bus0.awready, bus0.wready}), 32'b0_0_00_00_111);
        chk("reset0_rdata", bus0.rdata, 32'h0);
        chk("reset1_ctl", 32'({bus1.rvalid, bus1.bvalid, bus1.rresp, bus1.bresp,
                               bus1.arready, bus1.awready, bus1.wready}), 32'b0_0_00_00_111);
        rst_n = 1'b1;
        tick();

        // Zero-latency vectors.
        for (int i = 0; i < 14; i++) begin
            if (tv[i].wr) begin
                wr(1'b0, tv[i].addr, tv[i].data, tv[i].strb, r, lat);
                chk($sformatf("v%0d_bresp", i), 32'(r), 32'(tv[i].exp_resp));
                chk($sformatf("v%0d_blat", i), 32'(lat), 32'd1);
            end else begin
                rd(1'b0, tv[i].addr, d, r, lat);
                chk($sformatf("v%0d_rdata", i), d, tv[i].exp_data);
                chk($sformatf("v%0d_rresp", i), 32'(r), 32'(tv[i].exp_resp));
                chk($sformatf("v%0d_rlat", i), 32'(lat), 32'd1);
            end
        end

        // Same-edge read and write commit to one word: read sees the old value.
        wr(1'b0, 32'h8000_0040, 32'h1111_1111, 4'hF, r, lat);
        bus0.araddr = 32'h8000_0040; bus0.arvalid = 1'b1; bus0.rready = 1'b1;
        bus0.awaddr = 32'h8000_0040; bus0.awvalid = 1'b1;
        bus0.wdata = 32'h2222_2222; bus0.wstrb = 4'hF; bus0.wvalid = 1'b1; bus0.bready = 1'b1;
        tick();
        bus0.arvalid = 1'b0; bus0.awvalid = 1'b0; bus0.wvalid = 1'b0;
        chk("coll_rvalid_bvalid", 32'({bus0.rvalid, bus0.bvalid, bus0.arready}), 32'b110);
        chk("coll_rdata_old", bus0.rdata, 32'h1111_1111);
        tick();
        rd(1'b0, 32'h8000_0040, d, r, lat);
        chk("coll_rdata_new", d, 32'h2222_2222);

        // WRITE_LAT=2: AW three cycles ahead of W.
        bus1.awaddr = 32'h8000_0020; bus1.awvalid = 1'b1; bus1.bready = 1'b1;
        tick();
        bus1.awvalid = 1'b0;
        chk("awfirst_readys", 32'({bus1.awready, bus1.wready}), 32'b01);
        tick(); tick();
        bus1.wdata = 32'h0102_0304; bus1.wstrb = 4'hF; bus1.wvalid = 1'b1;
        tick();
        bus1.wvalid = 1'b0;
        chk("awfirst_readys_both", 32'({bus1.awready, bus1.wready, bus1.bvalid}), 32'b000);
        lat = 1;
        while (!bus1.bvalid && lat < 30) begin tick(); lat++; end
        chk("awfirst_blat", 32'(lat), 32'd3);
        chk("awfirst_bresp", 32'(bus1.bresp), 32'd0);
        tick();
        chk("awfirst_idle", 32'({bus1.awready, bus1.wready, bus1.bvalid}), 32'b110);

        // W ahead of AW.
        bus1.wdata = 32'h0A0B_0C0D; bus1.wstrb = 4'hF; bus1.wvalid = 1'b1;
        tick();
        bus1.wvalid = 1'b0;
        chk("wfirst_readys", 32'({bus1.awready, bus1.wready}), 32'b10);
        tick();
        bus1.awaddr = 32'h8000_0024; bus1.awvalid = 1'b1;
        tick();
        bus1.awvalid = 1'b0;
        lat = 1;
        while (!bus1.bvalid && lat < 30) begin tick(); lat++; end
        chk("wfirst_blat", 32'(lat), 32'd3);
        tick();

        // READ_LAT=3 with rready held low for 5 cycles.
        bus1.araddr = 32'h8000_0020; bus1.arvalid = 1'b1; bus1.rready = 1'b0;
        tick();
        bus1.arvalid = 1'b0;
        chk("rlat3_arready_low", 32'(bus1.arready), 32'd0);
        lat = 1;
        while (!bus1.rvalid && lat < 30) begin tick(); lat++; end
        chk("rlat3_rlat", 32'(lat), 32'd4);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("rlat3_hold%0d", c),
                32'({bus1.rvalid, bus1.arready, bus1.rresp}), 32'b1_0_00);
            chk($sformatf("rlat3_hold%0d_rdata", c), bus1.rdata, 32'h0102_0304);
            tick();
        end
        bus1.rready = 1'b1;
        tick();
        chk("rlat3_done", 32'({bus1.rvalid, bus1.arready}), 32'b01);
        rd(1'b1, 32'h8000_0024, d, r, lat);
        chk("wfirst_rdata", d, 32'h0A0B_0C0D);

        // Reset during W_WAIT aborts the write.
        wr(1'b1, 32'h8000_0030, 32'h7777_7777, 4'hF, r, lat);
        bus1.awaddr = 32'h8000_0030; bus1.wdata = 32'h9999_9999; bus1.wstrb = 4'hF;
        bus1.awvalid = 1'b1; bus1.wvalid = 1'b1; bus1.bready = 1'b1;
        tick();
        bus1.awvalid = 1'b0; bus1.wvalid = 1'b0;
        chk("rstmid_in_wait", 32'({bus1.awready, bus1.wready, bus1.bvalid}), 32'b000);
        rst_n = 1'b0;
        #1;
        chk("rstmid_async", 32'({bus1.bvalid, bus1.arready, bus1.awready, bus1.wready}), 32'b0111);
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        chk("rstmid_no_bvalid", 32'(bus1.bvalid), 32'd0);
        rd(1'b1, 32'h8000_0030, d, r, lat);
        chk("rstmid_word_kept", d, 32'h7777_7777);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
